// File: rtl/tlb_entry_state_pkg.sv
// Shared types and constants for the 4-entry TLB replacement-state slice.
package tlb_pkg;

  localparam int TLB_ENTRIES = 4;
  localparam int CNT_W       = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    COMMIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Index of the lowest set bit; an all-zero vector maps to entry 0.
  function automatic logic [1:0] first_one(input logic [TLB_ENTRIES-1:0] v);
    first_one = 2'd0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) first_one = 2'(i);
    end
  endfunction

endpackage

// File: rtl/tlb_entry_state_if.sv
// Upstream-facing bundle: lookup hits, flushes and the refill handshake.
// Refill handshake: a refill is accepted on a clk edge where refill_valid and
// refill_ready are both 1; refill_G must be stable while refill_valid is high,
// and refill_done pulses for one cycle with refill_entry once it is written.
interface tlb_entry_state_if;
  import tlb_pkg::*;

  logic                   hit_valid;
  logic [TLB_ENTRIES-1:0] hit_vec;
  logic                   refill_valid;
  logic                   refill_ready;
  logic                   refill_G;
  logic                   refill_done;
  logic [1:0]             refill_entry;
  logic                   flush;
  logic                   flush_all;

  modport master (
    output hit_valid, hit_vec, refill_valid, refill_G, flush, flush_all,
    input  refill_ready, refill_done, refill_entry
  );

  modport slave (
    input  hit_valid, hit_vec, refill_valid, refill_G, flush, flush_all,
    output refill_ready, refill_done, refill_entry
  );

endinterface

// File: rtl/tlb_entry_state_acc_counter.sv
// Per-entry access counter: optional halving on an age tick, then a
// saturating increment; a load overrides both.
module tlb_acc_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         age_tick,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  logic [W-1:0] base;

  assign base = age_tick ? (cnt >> 1) : cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (base != '1)) begin
      cnt <= base + 1'b1;
    end else begin
      cnt <= base;
    end
  end

endmodule

// File: rtl/tlb_entry_state.sv
// Replacement state for a 4-entry TLB: valid/PTE_G/access counts, aging,
// flushes, and the refill sequencer that writes the arbiter-chosen victim.
module tlb_entry_state import tlb_pkg::*; #(
  parameter int CNT_W      = 12,
  parameter int AGE_PERIOD = 1024,
  parameter int INIT_CNT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  tlb_entry_state_if.slave     bus,
  input  logic [3:0]           entry_select,
  output logic                 entry0_valid,
  output logic [CNT_W-1:0]     entry0_acc_count,
  output logic                 entry0_PTE_G,
  output logic                 entry1_valid,
  output logic [CNT_W-1:0]     entry1_acc_count,
  output logic                 entry1_PTE_G,
  output logic                 entry2_valid,
  output logic [CNT_W-1:0]     entry2_acc_count,
  output logic                 entry2_PTE_G,
  output logic                 entry3_valid,
  output logic [CNT_W-1:0]     entry3_acc_count,
  output logic                 entry3_PTE_G,
  output state_t               state_dbg
);

  localparam int AGE_W = (AGE_PERIOD > 2) ? $clog2(AGE_PERIOD) : 1;

  logic [AGE_W-1:0]       age_cnt;
  logic                   age_tick;
  state_t                 state;
  logic                   g_q;
  logic [1:0]             victim;
  logic                   done_q;
  logic [1:0]             entry_q;
  logic                   commit;
  logic [TLB_ENTRIES-1:0] valid;
  logic [TLB_ENTRIES-1:0] pte_g;
  logic [CNT_W-1:0]       cnt [TLB_ENTRIES];

  assign age_tick = (age_cnt == AGE_W'(AGE_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_cnt <= '0;
    end else if (age_tick) begin
      age_cnt <= '0;
    end else begin
      age_cnt <= age_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      g_q     <= 1'b0;
      victim  <= 2'd0;
      done_q  <= 1'b0;
      entry_q <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.refill_valid) begin
            g_q   <= bus.refill_G;
            state <= LATCH;
          end
        end
        LATCH: begin
          victim <= first_one(entry_select);
          state  <= COMMIT;
        end
        COMMIT: begin
          done_q  <= 1'b1;
          entry_q <= victim;
          state   <= RESP;
        end
        RESP: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign commit           = (state == COMMIT);
  assign bus.refill_ready = (state == IDLE);
  assign bus.refill_done  = done_q;
  assign bus.refill_entry = entry_q;
  assign state_dbg        = state;

  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_entry
    logic is_victim;
    assign is_victim = commit && (victim == 2'(i));

    // The commit write wins over any flush landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid[i] <= 1'b0;
        pte_g[i] <= 1'b0;
      end else if (is_victim) begin
        valid[i] <= 1'b1;
        pte_g[i] <= g_q;
      end else if (bus.flush_all || (bus.flush && !pte_g[i])) begin
        valid[i] <= 1'b0;
      end
    end

    tlb_acc_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .age_tick (age_tick),
      .inc      (bus.hit_valid && bus.hit_vec[i] && valid[i]),
      .load     (is_victim),
      .load_val (CNT_W'(INIT_CNT)),
      .cnt      (cnt[i])
    );
  end

  assign entry0_valid     = valid[0];
  assign entry1_valid     = valid[1];
  assign entry2_valid     = valid[2];
  assign entry3_valid     = valid[3];
  assign entry0_PTE_G     = pte_g[0];
  assign entry1_PTE_G     = pte_g[1];
  assign entry2_PTE_G     = pte_g[2];
  assign entry3_PTE_G     = pte_g[3];
  assign entry0_acc_count = cnt[0];
  assign entry1_acc_count = cnt[1];
  assign entry2_acc_count = cnt[2];
  assign entry3_acc_count = cnt[3];

endmodule
